// File: rtl/cadr_timing_pkg.sv
// cadr_timing_pkg
//   Shared definitions for the CADR cycle sequencer: the sequencer state
//   encoding, the number of delay-line taps and a width helper used to size
//   the tick counter.
//   No ports (package).
package cadr_timing_pkg;

    // Sequencer states: waiting, free-running cycles, or a single step.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    // One tap per 10 ns stage of the old TD50 delay line.
    localparam int NTAPS = 5;

    // Bits needed to count 0..value-1. Never returns less than 1.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/cadr_tap_line.sv
// cadr_tap_line
//   Synchronous stand-in for the tapped delay line: a shift register that
//   delays the source strobe by 1..NTAPS clocks.
//   Ports:
//     clk    in   fast clock, one tick per 10 ns tap
//     reset  in   asynchronous active-high reset, clears every stage
//     i_src  in   source strobe to be delayed
//     o_tap  out  o_tap[k] is i_src delayed by k+1 clocks
module cadr_tap_line
    import cadr_timing_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_src,
    output logic [NTAPS-1:0] o_tap
);

    logic [NTAPS-1:0] r_stages;

    // Each clock the strobe moves one stage further down the line.
    // Reset empties the line at once so no stale pulse leaks out later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stages <= '0;
        end else begin
            r_stages <= {r_stages[NTAPS-2:0], i_src};
        end
    end

    assign o_tap = r_stages;

endmodule

// File: rtl/cadr_cycle_sequencer.sv
// cadr_cycle_sequencer
//   Replaces the TD50 delay lines of the CADR clock generator. Produces the
//   machine-cycle source strobe and its five delayed taps from one fast
//   clock, with short/long cycle selection, hold and single-step.
//   Ports:
//     clk          in   fast clock, each tick stands for one 10 ns tap
//     reset        in   asynchronous active-high reset
//     run          in   level, run cycles back-to-back
//     step         in   one-clock pulse, run one cycle (honoured only in IDLE)
//     hold         in   level, blocks the start of any new cycle
//     ilong        in   long-cycle request, sampled when a cycle starts
//     src          out  cycle source strobe, high for the first PULSE_TICKS ticks
//     tap          out  tap[k] is src delayed by k+1 clocks
//     cycle_start  out  one-clock pulse at tick 0
//     cycle_end    out  one-clock pulse at the last tick
//     busy         out  high while a cycle is in progress
//     cur_long     out  ilong as latched for the current cycle
//     cycle_count  out  completed cycles, wraps silently
module cadr_cycle_sequencer
    import cadr_timing_pkg::*;
#(
    parameter int SHORT_TICKS = 10,
    parameter int LONG_TICKS  = 14,
    parameter int PULSE_TICKS = 5,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic             hold,
    input  logic             ilong,
    output logic             src,
    output logic [NTAPS-1:0] tap,
    output logic             cycle_start,
    output logic             cycle_end,
    output logic             busy,
    output logic             cur_long,
    output logic [CNT_W-1:0] cycle_count
);

    // The taps must have drained before the next cycle can begin, so a cycle
    // has to be at least PULSE_TICKS + NTAPS ticks long.
    generate
        if (PULSE_TICKS < 1 || SHORT_TICKS < PULSE_TICKS + NTAPS ||
            LONG_TICKS < SHORT_TICKS) begin : g_badParams
            $error("cadr_cycle_sequencer: illegal tick parameters");
        end
    endgenerate

    localparam int TICK_W = clog2(LONG_TICKS);
    localparam logic [TICK_W-1:0] LAST_SHORT = TICK_W'(SHORT_TICKS - 1);
    localparam logic [TICK_W-1:0] LAST_LONG  = TICK_W'(LONG_TICKS - 1);
    localparam logic [TICK_W-1:0] PULSE_END  = TICK_W'(PULSE_TICKS);

    state_t            r_state;
    logic [TICK_W-1:0] r_tick;
    logic              r_src;
    logic              r_cycleStart;
    logic              r_cycleEnd;
    logic              r_busy;
    logic              r_curLong;
    logic [CNT_W-1:0]  r_count;

    logic [TICK_W-1:0] w_lastTick;
    logic [TICK_W-1:0] w_tickNext;
    logic              w_atEnd;
    logic              w_startFromIdle;
    logic              w_chainNext;

    assign w_lastTick      = r_curLong ? LAST_LONG : LAST_SHORT;
    assign w_tickNext      = r_tick + 1'b1;
    assign w_atEnd         = (r_tick == w_lastTick);
    // hold beats run, run beats step.
    assign w_startFromIdle = !hold && (run || step);
    assign w_chainNext     = (r_state == ST_RUN) && run && !hold;

    // Main sequencer. A cycle starts on the edge that leaves IDLE (or on the
    // edge after the last tick when chaining), so tick 0 is visible right after
    // that edge. cycle_end and the count update land together on the edge that
    // enters the last tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_tick       <= '0;
            r_src        <= 1'b0;
            r_cycleStart <= 1'b0;
            r_cycleEnd   <= 1'b0;
            r_busy       <= 1'b0;
            r_curLong    <= 1'b0;
            r_count      <= '0;
        end else begin
            r_cycleStart <= 1'b0;
            r_cycleEnd   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_startFromIdle) begin
                        r_state      <= run ? ST_RUN : ST_STEP;
                        r_tick       <= '0;
                        r_src        <= 1'b1;
                        r_cycleStart <= 1'b1;
                        r_busy       <= 1'b1;
                        r_curLong    <= ilong;
                    end
                end
                ST_RUN, ST_STEP: begin
                    if (w_atEnd) begin
                        if (w_chainNext) begin
                            r_tick       <= '0;
                            r_src        <= 1'b1;
                            r_cycleStart <= 1'b1;
                            r_curLong    <= ilong;
                        end else begin
                            r_state <= ST_IDLE;
                            r_tick  <= '0;
                            r_src   <= 1'b0;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_tick <= w_tickNext;
                        r_src  <= (w_tickNext < PULSE_END);
                        if (w_tickNext == w_lastTick) begin
                            r_cycleEnd <= 1'b1;
                            r_count    <= r_count + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_src   <= 1'b0;
                end
            endcase
        end
    end

    cadr_tap_line u_tapLine (
        .clk   (clk),
        .reset (reset),
        .i_src (r_src),
        .o_tap (tap)
    );

    assign src         = r_src;
    assign cycle_start = r_cycleStart;
    assign cycle_end   = r_cycleEnd;
    assign busy        = r_busy;
    assign cur_long    = r_curLong;
    assign cycle_count = r_count;

endmodule

// File: tb/tb_cadr_cycle_sequencer.sv
// Directed bench for cadr_cycle_sequencer. A second instance with a 4-bit
// counter exercises the counter wrap.
module tb_cadr_cycle_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        hold = 1'b0;
    logic        ilong = 1'b0;
    logic        src;
    logic [4:0]  tap;
    logic        cycleStart;
    logic        cycleEnd;
    logic        busy;
    logic        curLong;
    logic [15:0] cycleCount;

    logic        reset4 = 1'b1;
    logic        run4 = 1'b0;
    logic        src4;
    logic [4:0]  tap4;
    logic        cycleStart4;
    logic        cycleEnd4;
    logic        busy4;
    logic        curLong4;
    logic [3:0]  cycleCount4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cadr_cycle_sequencer #(.CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .step        (step),
        .hold        (hold),
        .ilong       (ilong),
        .src         (src),
        .tap         (tap),
        .cycle_start (cycleStart),
        .cycle_end   (cycleEnd),
        .busy        (busy),
        .cur_long    (curLong),
        .cycle_count (cycleCount)
    );

    cadr_cycle_sequencer #(.CNT_W(4)) dut4 (
        .clk         (clk),
        .reset       (reset4),
        .run         (run4),
        .step        (1'b0),
        .hold        (1'b0),
        .ilong       (1'b0),
        .src         (src4),
        .tap         (tap4),
        .cycle_start (cycleStart4),
        .cycle_end   (cycleEnd4),
        .busy        (busy4),
        .cur_long    (curLong4),
        .cycle_count (cycleCount4)
    );

    // Expected src after edge m of back-to-back short cycles (edge 1 = tick 0).
    function automatic logic srcModel(input int m);
        return (m >= 1) && (((m - 1) % 10) < 5);
    endfunction

    // Expected taps after edge n: tap[k] is src from k+1 edges earlier.
    function automatic logic [4:0] tapModel(input int n);
        logic [4:0] t;
        for (int k = 0; k < 5; k++) begin
            t[k] = srcModel(n - k - 1);
        end
        return t;
    endfunction

    task automatic tickClk();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic h,
                                 input logic l);
        run   = r;
        step  = s;
        hold  = h;
        ilong = l;
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tickClk();
        tickClk();
        reset = 1'b0;
    endtask

    initial begin
        // Reset state.
        doReset();
        checkOutput("rst_src", src, 0);
        checkOutput("rst_tap", tap, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_count", cycleCount, 0);
        checkOutput("rst_start", cycleStart, 0);
        checkOutput("rst_curLong", curLong, 0);

        // Back-to-back short cycles.
        $display("[TB] run, short cycles");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int n = 1; n <= 30; n++) begin
            tickClk();
            checkOutput($sformatf("t1_src_e%0d", n), src, srcModel(n));
            checkOutput($sformatf("t1_tap_e%0d", n), tap, tapModel(n));
            checkOutput($sformatf("t1_start_e%0d", n), cycleStart, ((n - 1) % 10) == 0);
            checkOutput($sformatf("t1_end_e%0d", n), cycleEnd, ((n - 1) % 10) == 9);
            checkOutput($sformatf("t1_count_e%0d", n), cycleCount, n / 10);
            checkOutput($sformatf("t1_busy_e%0d", n), busy, 1);
        end
        checkOutput("t1_count_final", cycleCount, 3);

        // Long cycle then short, ilong wiggled mid-cycle.
        $display("[TB] long then short");
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        for (int n = 1; n <= 24; n++) begin
            tickClk();
            checkOutput($sformatf("t2_start_e%0d", n), cycleStart, (n == 1) || (n == 15));
            checkOutput($sformatf("t2_end_e%0d", n), cycleEnd, (n == 14) || (n == 24));
            checkOutput($sformatf("t2_curLong_e%0d", n), curLong, n <= 14);
            checkOutput($sformatf("t2_src_e%0d", n), src, (n <= 5) || (n >= 15 && n <= 19));
            if (n == 1)  ilong = 1'b0;
            if (n == 17) ilong = 1'b1;
            if (n == 20) ilong = 1'b0;
            if (n == 24) run = 1'b0;
        end
        checkOutput("t2_count", cycleCount, 2);
        tickClk();
        checkOutput("t2_busy_after", busy, 0);

        // Single step; a second step while busy is ignored.
        $display("[TB] single step");
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        tickClk();
        checkOutput("t3_busy_e1", busy, 1);
        checkOutput("t3_src_e1", src, 1);
        step = 1'b0;
        for (int n = 2; n <= 10; n++) begin
            tickClk();
            if (n == 3) step = 1'b1;
            if (n == 4) step = 1'b0;
        end
        checkOutput("t3_end_e10", cycleEnd, 1);
        checkOutput("t3_count_e10", cycleCount, 1);
        tickClk();
        checkOutput("t3_busy_e11", busy, 0);
        checkOutput("t3_src_e11", src, 0);
        checkOutput("t3_tap_e11", tap, 0);
        tickClk();
        tickClk();
        tickClk();
        checkOutput("t3_busy_idle", busy, 0);
        checkOutput("t3_count_idle", cycleCount, 1);

        // Hold raised at tick 3 lets the cycle finish, then blocks the next.
        $display("[TB] hold");
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int n = 1; n <= 10; n++) begin
            tickClk();
            if (n == 4) hold = 1'b1;
        end
        checkOutput("t4_end_e10", cycleEnd, 1);
        checkOutput("t4_count_e10", cycleCount, 1);
        tickClk();
        checkOutput("t4_busy_e11", busy, 0);
        checkOutput("t4_src_e11", src, 0);
        tickClk();
        tickClk();
        checkOutput("t4_busy_e13", busy, 0);
        checkOutput("t4_start_e13", cycleStart, 0);
        hold = 1'b0;
        tickClk();
        checkOutput("t4_busy_e14", busy, 1);
        checkOutput("t4_src_e14", src, 1);
        checkOutput("t4_start_e14", cycleStart, 1);

        // Asynchronous reset in the middle of a cycle.
        $display("[TB] mid-cycle reset");
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int n = 1; n <= 17; n++) begin
            tickClk();
        end
        checkOutput("t5_tap_pre", tap, 5'b11110);
        checkOutput("t5_count_pre", cycleCount, 1);
        reset = 1'b1;
        #1;
        checkOutput("t5_src_rst", src, 0);
        checkOutput("t5_tap_rst", tap, 0);
        checkOutput("t5_busy_rst", busy, 0);
        checkOutput("t5_count_rst", cycleCount, 0);
        @(negedge clk);
        reset = 1'b0;
        tickClk();
        checkOutput("t5_src_first", src, 1);
        checkOutput("t5_start_first", cycleStart, 1);
        checkOutput("t5_tap_first", tap, 0);

        // 4-bit counter wraps after 16 cycles, strobes stay regular.
        $display("[TB] counter wrap");
        reset4 = 1'b0;
        run4   = 1'b1;
        for (int n = 1; n <= 160; n++) begin
            tickClk();
            checkOutput($sformatf("t6_src_e%0d", n), src4, srcModel(n));
            checkOutput($sformatf("t6_tap_e%0d", n), tap4, tapModel(n));
            checkOutput($sformatf("t6_count_e%0d", n), cycleCount4, (n / 10) % 16);
        end
        checkOutput("t6_count_wrapped", cycleCount4, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
